// File: rtl/mon_frame_scheduler_if.sv
// mon_frame_scheduler_if: request, FIFO-status and frame-strobe bundle around the monitor frame scheduler
//   slave  : scheduler side (takes requests and FIFO flags, drives grants, strobes, counters)
//   master : environment side (requesters, FIFO controller, Aurora slot source)
interface mon_frame_scheduler_if #(
    parameter int N_REQ = 2,
    parameter int DW    = 26
);
    logic [N_REQ-1:0]    ReqValid;
    logic [N_REQ*DW-1:0] ReqData;
    logic [N_REQ-1:0]    ReqReady;
    logic [7:0]          FifoFull;
    logic [7:0]          FifoEmpty;
    logic                FrameSlot;
    logic                AutoFrameEn;
    logic                NewRegData;
    logic [DW-1:0]       RegData;
    logic                SendFrame;
    logic                Busy;
    logic [15:0]         FrameCnt;
    logic [15:0]         SkipCnt;

    modport slave (
        input  ReqValid, ReqData, FifoFull, FifoEmpty, FrameSlot, AutoFrameEn,
        output ReqReady, NewRegData, RegData, SendFrame, Busy, FrameCnt, SkipCnt
    );

    modport master (
        output ReqValid, ReqData, FifoFull, FifoEmpty, FrameSlot, AutoFrameEn,
        input  ReqReady, NewRegData, RegData, SendFrame, Busy, FrameCnt, SkipCnt
    );
endinterface

// File: rtl/mon_frame_scheduler.sv
// mon_frame_scheduler: round-robin register-readback arbiter and service-frame slot scheduler for the monitor FIFOs
//   clk, Reset : clock and synchronous active-high reset
//   bus.slave  : requests in (ReqValid/ReqData), one-hot grant out (ReqReady), FIFO flags in,
//                FrameSlot/AutoFrameEn in, NewRegData/RegData/SendFrame strobes out, Busy and counters out
module mon_frame_scheduler #(
    parameter int N_REQ     = 2,
    parameter int DW        = 26,
    parameter int LOAD_GAP  = 2,
    parameter int FRAME_GAP = 2
) (
    input logic clk,
    input logic Reset,
    mon_frame_scheduler_if.slave bus
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} state_t;

    state_t        state, state_nx;
    logic [1:0]    gap_cnt, gap_nx;
    logic [PW-1:0] rr_ptr, gnt_idx;
    logic [DW-1:0] reg_data;
    logic [15:0]   frame_cnt, skip_cnt;
    logic          found, go_frame, skip, take;

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.ReqValid[(int'(rr_ptr) + k) % N_REQ]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    // A usable slot pre-empts the request path; a skipped slot leaves it open
    assign go_frame = state == IDLE && bus.FrameSlot && (!(&bus.FifoEmpty) || bus.AutoFrameEn);
    assign skip     = state == IDLE && bus.FrameSlot && !go_frame;
    assign take     = !Reset && state == IDLE && !go_frame && found && bus.FifoFull == 8'h00;

    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        case (state)
            IDLE:  state_nx = go_frame ? FRAME : take ? LOAD : IDLE;
            LOAD:  begin
                state_nx = GAP;
                gap_nx   = 2'(LOAD_GAP - 1);
            end
            FRAME: begin
                state_nx = GAP;
                gap_nx   = 2'(FRAME_GAP - 1);
            end
            default: begin
                state_nx = gap_cnt == 2'd0 ? IDLE : GAP;
                gap_nx   = gap_cnt - 2'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            rr_ptr    <= '0;
            reg_data  <= '0;
            frame_cnt <= '0;
            skip_cnt  <= '0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
            if (take) begin
                rr_ptr   <= int'(gnt_idx) == N_REQ - 1 ? '0 : gnt_idx + 1'b1;
                reg_data <= bus.ReqData[gnt_idx * DW +: DW];
            end
            if (state == FRAME)
                frame_cnt <= frame_cnt + 16'd1;
            if (skip)
                skip_cnt <= skip_cnt + 16'd1;
        end
    end

    assign bus.ReqReady   = take ? N_REQ'(1) << gnt_idx : '0;
    assign bus.NewRegData = state == LOAD;
    assign bus.SendFrame  = state == FRAME;
    assign bus.Busy       = state != IDLE;
    assign bus.RegData    = reg_data;
    assign bus.FrameCnt   = frame_cnt;
    assign bus.SkipCnt    = skip_cnt;
endmodule

// File: tb/tb_mon_frame_scheduler.sv
// tb_mon_frame_scheduler: self-checking bench for mon_frame_scheduler
module tb_mon_frame_scheduler;
    localparam int N  = 2;
    localparam int DW = 26;
    localparam int W  = N * DW;

    logic clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 clk = ~clk;

    mon_frame_scheduler_if #(.N_REQ(N), .DW(DW)) b ();

    mon_frame_scheduler #(.N_REQ(N), .DW(DW), .LOAD_GAP(2), .FRAME_GAP(2)) dut (
        .clk  (clk),
        .Reset(Reset),
        .bus  (b)
    );

    typedef struct {
        logic [1:0] rv;
        logic [7:0] ff;
        logic [7:0] fe;
        logic       fs;
        logic       ae;
        logic [1:0] rdy;
        logic       load;
        logic       frame;
        logic       skip;
        string      name;
    } vec_t;

    vec_t          tbl[10];
    int            tests = 0, fails = 0, cyc = 0, m_rr = 0, nframe = 0;
    logic [DW-1:0] sbq[$];
    int            gq[$], lq[$];
    logic [15:0]   s0, f0;
    int            n0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Grant model pushes the expected word; each load pops and compares it
    task automatic monitor();
        int e;
        if (|b.ReqReady) begin
            e = -1;
            for (int k = 0; k < N; k++)
                if (e < 0 && b.ReqValid[(m_rr + k) % N]) e = (m_rr + k) % N;
            if (e < 0) chk("grant_without_valid", 32'(b.ReqReady), 0);
            else begin
                chk("grant_onehot", 32'(b.ReqReady), 32'(1 << e));
                sbq.push_back(b.ReqData[e * DW +: DW]);
                gq.push_back(e);
                m_rr = (e + 1) % N;
            end
        end
        if (b.NewRegData) begin
            lq.push_back(cyc);
            if (sbq.size() == 0) chk("load_without_grant", 32'(b.NewRegData), 0);
            else chk("regdata", 32'(b.RegData), 32'(sbq.pop_front()));
            chk("load_frame_exclusive", 32'(b.SendFrame), 0);
        end
        if (b.SendFrame) nframe++;
        if (Reset) begin
            m_rr = 0;
            sbq.delete();
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle();
        int n = 0;
        b.ReqValid  = '0;
        b.FrameSlot = 1'b0;
        while (b.Busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (b.Busy !== 1'b0) chk("idle_timeout", 32'(b.Busy), 0);
    endtask

    initial begin
        tbl[0] = '{2'b11, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, "v_rr_from1"};
        tbl[1] = '{2'b01, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "v_req0_at_ptr"};
        tbl[2] = '{2'b01, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, "v_req0_wrap"};
        tbl[3] = '{2'b11, 8'h80, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "v_full_lane7"};
        tbl[4] = '{2'b00, 8'h00, 8'hFF, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, "v_skip"};
        tbl[5] = '{2'b00, 8'h00, 8'h7F, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, "v_frame_data"};
        tbl[6] = '{2'b11, 8'h00, 8'hFF, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "v_frame_auto"};
        tbl[7] = '{2'b11, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, "v_rr_after_frame"};
        tbl[8] = '{2'b10, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "v_full_lane0"};
        tbl[9] = '{2'b00, 8'h00, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "v_quiet"};

        b.ReqValid = '0; b.ReqData = '0; b.FifoFull = '0; b.FifoEmpty = 8'hFF;
        b.FrameSlot = 1'b0; b.AutoFrameEn = 1'b0;

        // Reset with inputs toggling
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b.ReqValid    = 2'($urandom);
            b.ReqData     = W'({$urandom(), $urandom()});
            b.FifoFull    = 8'($urandom);
            b.FifoEmpty   = 8'($urandom);
            b.FrameSlot   = 1'($urandom);
            b.AutoFrameEn = 1'($urandom);
            #1;
            chk("rst_ready", 32'(b.ReqReady), 0);
            step();
            chk("rst_strobes_busy", {29'd0, b.NewRegData, b.SendFrame, b.Busy}, 0);
            chk("rst_regdata", 32'(b.RegData), 0);
            chk("rst_counters", {b.FrameCnt, b.SkipCnt}, 0);
        end
        Reset = 1'b0;
        b.FifoFull = '0; b.FifoEmpty = 8'hFF; b.FrameSlot = 1'b0; b.AutoFrameEn = 1'b0;

        // Round-robin with both requesters held
        b.ReqValid = 2'b11;
        #1;
        chk("first_grant_req0", 32'(b.ReqReady), 32'h1);
        gq.delete(); lq.delete();
        for (int i = 0; i < 16; i++) begin
            b.ReqData = W'({$urandom(), $urandom()});
            step();
        end
        b.ReqValid = '0;
        chk("rr_grant_count", gq.size(), 4);
        for (int i = 0; i < gq.size() && i < 4; i++) chk("rr_order", gq[i], i % 2);
        chk("rr_load_count", lq.size(), 4);
        for (int i = 0; i + 1 < lq.size(); i++) chk("rr_load_spacing", lq[i+1] - lq[i], 4);

        // Backpressure
        b.FifoFull = 8'h04; b.ReqValid = 2'b01; lq.delete();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 32'(b.ReqReady), 0);
            step();
        end
        chk("bp_no_load", lq.size(), 0);
        b.FifoFull = 8'h00;
        #1;
        chk("bp_release_ready", 32'(b.ReqReady), 32'h1);
        step();
        chk("bp_release_load", 32'(b.NewRegData), 1);
        wait_idle();

        // Frame slot collides with a request
        b.FifoEmpty = 8'hFE; b.FrameSlot = 1'b1; b.ReqValid = 2'b01;
        #1;
        chk("col_ready", 32'(b.ReqReady), 0);
        step();
        b.FrameSlot = 1'b0;
        chk("col_send", 32'(b.SendFrame), 1);
        chk("col_noload", 32'(b.NewRegData), 0);
        step();
        chk("col_framecnt", 32'(b.FrameCnt), 1);
        chk("col_gap1", 32'(b.ReqReady), 0);
        step();
        chk("col_gap2", 32'(b.ReqReady), 0);
        step();
        chk("col_grant", 32'(b.ReqReady), 32'h1);
        step();
        chk("col_load", 32'(b.NewRegData), 1);
        wait_idle();

        // Skipped slots, then auto frames
        b.FifoEmpty = 8'hFF; b.AutoFrameEn = 1'b0; s0 = b.SkipCnt; n0 = nframe;
        for (int i = 0; i < 5; i++) begin
            b.FrameSlot = 1'b1;
            step();
            b.FrameSlot = 1'b0;
            step();
        end
        chk("skip_cnt", 32'(b.SkipCnt), 32'(s0) + 5);
        chk("skip_no_frame", nframe - n0, 0);
        b.AutoFrameEn = 1'b1; f0 = b.FrameCnt;
        for (int i = 0; i < 5; i++) begin
            b.FrameSlot = 1'b1;
            step();
            b.FrameSlot = 1'b0;
            chk("auto_send", 32'(b.SendFrame), 1);
            wait_idle();
        end
        chk("auto_framecnt", 32'(b.FrameCnt), 32'(f0) + 5);
        chk("auto_skip_held", 32'(b.SkipCnt), 32'(s0) + 5);
        b.AutoFrameEn = 1'b0;

        // Single-decision vectors from IDLE
        for (int i = 0; i < 10; i++) begin
            b.ReqValid = tbl[i].rv; b.FifoFull = tbl[i].ff; b.FifoEmpty = tbl[i].fe;
            b.FrameSlot = tbl[i].fs; b.AutoFrameEn = tbl[i].ae;
            b.ReqData = W'({$urandom(), $urandom()});
            s0 = b.SkipCnt;
            #1;
            chk({tbl[i].name, "_ready"}, 32'(b.ReqReady), 32'(tbl[i].rdy));
            step();
            b.FrameSlot = 1'b0;
            chk({tbl[i].name, "_load"}, 32'(b.NewRegData), 32'(tbl[i].load));
            chk({tbl[i].name, "_frame"}, 32'(b.SendFrame), 32'(tbl[i].frame));
            chk({tbl[i].name, "_skip"}, 32'(16'(b.SkipCnt - s0)), 32'(tbl[i].skip));
            wait_idle();
        end
        b.FifoFull = '0; b.FifoEmpty = 8'hFF; b.AutoFrameEn = 1'b0;

        // Reset in the LOAD cycle
        b.ReqValid = 2'b01;
        step();
        chk("t6_in_load", 32'(b.NewRegData), 1);
        Reset = 1'b1; b.ReqValid = '0;
        step();
        chk("t6_load_dropped", 32'(b.NewRegData), 0);
        chk("t6_idle", 32'(b.Busy), 0);
        chk("t6_counters", {b.FrameCnt, b.SkipCnt}, 0);
        chk("t6_regdata", 32'(b.RegData), 0);
        Reset = 1'b0;

        // FrameCnt wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        chk("wrap_preset", 32'(b.FrameCnt), 32'hFFFF);
        b.FifoEmpty = 8'hFE; b.FrameSlot = 1'b1;
        step();
        b.FrameSlot = 1'b0;
        chk("wrap_send", 32'(b.SendFrame), 1);
        step();
        chk("wrap_cnt", 32'(b.FrameCnt), 0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
